// File: rtl/insn_splitter_pkg.sv
// Shared CPU definitions: where the compressed-instruction (CIS) marker sits in
// a 32-bit word and how each 15-bit half is laid out. The decoder reuses these.
package insn_splitter_pkg;

  localparam int CIS_BIT    = 31;
  localparam int CIS_HALF_W = 15;
  localparam int INSN_W     = 32;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  // The high half keeps its own marker bit, so it is the top 16 bits unchanged.
  function automatic logic [INSN_W-1:0] cis_hi_insn(input logic [INSN_W-1:0] word);
    return {word[INSN_W-1:16], 16'h0000};
  endfunction

  // The low half has no marker of its own; re-insert one so decode sees a CIS half.
  function automatic logic [INSN_W-1:0] cis_lo_insn(input logic [INSN_W-1:0] word);
    return {1'b1, word[CIS_HALF_W-1:0], 16'h0000};
  endfunction

endpackage

// File: rtl/insn_splitter.sv
// One-register stage between prefetch and decode. Issues full words once and
// CIS words as two halves. Also handles branch targets landing on a low half.
module insn_splitter
  import insn_splitter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 30,
  parameter bit OPT_CIS       = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_new_pc,
  input  logic                     i_clear_cache,
  input  logic [ADDRESS_WIDTH+1:0] i_pc,
  input  logic                     i_pf_valid,
  input  logic [INSN_W-1:0]        i_pf_insn,
  input  logic [ADDRESS_WIDTH+1:0] i_pf_pc,
  input  logic                     i_pf_illegal,
  output logic                     o_pf_ready,
  output logic                     o_valid,
  output logic [INSN_W-1:0]        o_insn,
  output logic [ADDRESS_WIDTH+1:0] o_pc,
  output logic                     o_cis,
  output logic                     o_illegal,
  input  logic                     i_stalled_n
);

  localparam int PW = ADDRESS_WIDTH + 2;

  // Handshakes: prefetch word moves on i_pf_valid && o_pf_ready;
  // decode takes an instruction on o_valid && i_stalled_n.
  logic [INSN_W-1:0] r_word, w_word_nxt;
  logic [PW-1:0]     r_pc, w_pc_nxt;
  logic              r_ill, w_ill_nxt;
  logic              r_mis, w_mis_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_start_lo, w_start_lo_nxt;
  phase_t            r_phase, w_phase_nxt;

  logic w_cis, w_last, w_flush, w_accept, w_issue, w_new_cis;
  logic w_unused_pc;

  assign w_cis     = OPT_CIS && r_word[CIS_BIT];
  assign w_new_cis = OPT_CIS && i_pf_insn[CIS_BIT];
  assign w_last    = !w_cis || r_ill || (r_phase == PH_LO);
  assign w_flush   = i_new_pc || i_clear_cache;

  assign o_pf_ready = !r_valid || (i_stalled_n && w_last);
  assign w_accept   = i_pf_valid && o_pf_ready && !w_flush;
  assign w_issue    = r_valid && i_stalled_n;

  // Only the half-word select of the branch target matters here.
  assign w_unused_pc = ^{i_pc[PW-1:2], i_pc[0]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word     <= '0;
      r_pc       <= '0;
      r_ill      <= 1'b0;
      r_mis      <= 1'b0;
      r_valid    <= 1'b0;
      r_start_lo <= 1'b0;
      r_phase    <= PH_HI;
    end else begin
      r_word     <= w_word_nxt;
      r_pc       <= w_pc_nxt;
      r_ill      <= w_ill_nxt;
      r_mis      <= w_mis_nxt;
      r_valid    <= w_valid_nxt;
      r_start_lo <= w_start_lo_nxt;
      r_phase    <= w_phase_nxt;
    end
  end

  always_comb begin
    w_word_nxt     = r_word;
    w_pc_nxt       = r_pc;
    w_ill_nxt      = r_ill;
    w_mis_nxt      = r_mis;
    w_valid_nxt    = r_valid;
    w_start_lo_nxt = r_start_lo;
    w_phase_nxt    = r_phase;
    if (w_flush) begin
      w_valid_nxt    = 1'b0;
      w_phase_nxt    = PH_HI;
      w_start_lo_nxt = i_new_pc && i_pc[1];
    end else if (w_accept) begin
      w_valid_nxt    = 1'b1;
      w_word_nxt     = i_pf_insn;
      w_pc_nxt       = i_pf_pc;
      w_ill_nxt      = i_pf_illegal;
      // A low-half target on a word with no low half cannot be honoured.
      w_mis_nxt      = r_start_lo && !w_new_cis;
      w_phase_nxt    = (r_start_lo && w_new_cis) ? PH_LO : PH_HI;
      w_start_lo_nxt = 1'b0;
    end else if (w_issue) begin
      if (!w_last) begin
        w_phase_nxt = PH_LO;
      end else begin
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    o_valid   = r_valid;
    o_insn    = r_word;
    o_pc      = r_pc;
    o_cis     = 1'b0;
    o_illegal = r_ill || r_mis;
    if (r_mis) begin
      o_pc = r_pc + PW'(2);
    end else if (w_cis && !r_ill) begin
      o_cis = 1'b1;
      if (r_phase == PH_LO) begin
        o_insn = cis_lo_insn(r_word);
        o_pc   = r_pc + PW'(2);
      end else begin
        o_insn = cis_hi_insn(r_word);
      end
    end
  end

endmodule

// File: tb/tb_insn_splitter.sv
// Directed bench for insn_splitter: full words, CIS splitting, low-half branch
// targets, bus errors, stalls with flush, and asynchronous reset mid-split.
module tb_insn_splitter;

  localparam int AW = 30;
  localparam int PW = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          new_pc = 1'b0;
  logic          clear_cache = 1'b0;
  logic [PW-1:0] pc = '0;
  logic          pf_valid = 1'b0;
  logic [31:0]   pf_insn = '0;
  logic [PW-1:0] pf_pc = '0;
  logic          pf_illegal = 1'b0;
  logic          pf_ready;
  logic          o_valid;
  logic [31:0]   o_insn;
  logic [PW-1:0] o_pc;
  logic          o_cis;
  logic          o_illegal;
  logic          stalled_n = 1'b1;

  int checks = 0;
  int failures = 0;

  // {valid, cis, illegal, pf_ready, insn, pc}
  logic [67:0] obs;
  logic [67:0] exp_v;
  assign obs = {o_valid, o_cis, o_illegal, pf_ready, o_insn, o_pc};

  insn_splitter #(.ADDRESS_WIDTH(AW), .OPT_CIS(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_new_pc(new_pc), .i_clear_cache(clear_cache),
    .i_pc(pc), .i_pf_valid(pf_valid), .i_pf_insn(pf_insn), .i_pf_pc(pf_pc),
    .i_pf_illegal(pf_illegal), .o_pf_ready(pf_ready), .o_valid(o_valid),
    .o_insn(o_insn), .o_pc(o_pc), .o_cis(o_cis), .o_illegal(o_illegal),
    .i_stalled_n(stalled_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] w, input logic [PW-1:0] a, input logic ill);
    pf_valid = 1'b1; pf_insn = w; pf_pc = a; pf_illegal = ill;
  endtask

  task automatic idle_pf();
    pf_valid = 1'b0; pf_illegal = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    if (obs !== exp_v) begin
      $display("FAIL reset_state got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_words();
    drive_word(32'h0100_0000, 32'h100, 1'b0);
    step();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 32'h0100_0000, 32'h100};
    if (obs !== exp_v) begin
      $display("FAIL full_w0 got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    drive_word(32'h0200_0000, 32'h104, 1'b0);
    step();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 32'h0200_0000, 32'h104};
    if (obs !== exp_v) begin
      $display("FAIL full_w1 got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    idle_pf();
    step();
    if (o_valid !== 1'b0) begin
      $display("FAIL full_drain got=%b exp=0", o_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_cis_split();
    drive_word(32'h8001_8002, 32'h200, 1'b0);
    step();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 32'h8001_0000, 32'h200};
    if (obs !== exp_v) begin
      $display("FAIL cis_hi got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    idle_pf();
    step();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 32'h8002_0000, 32'h202};
    if (obs !== exp_v) begin
      $display("FAIL cis_lo got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
    if (o_valid !== 1'b0) begin
      $display("FAIL cis_drain got=%b exp=0", o_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_low_target();
    new_pc = 1'b1; pc = 32'h302;
    step();
    new_pc = 1'b0;
    drive_word(32'h8001_8002, 32'h300, 1'b0);
    step();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 32'h8002_0000, 32'h302};
    if (obs !== exp_v) begin
      $display("FAIL lo_target_cis got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    idle_pf();
    step();
    if (o_valid !== 1'b0) begin
      $display("FAIL lo_target_once got=%b exp=0", o_valid); failures++;
    end
    checks++;
    new_pc = 1'b1; pc = 32'h302;
    step();
    new_pc = 1'b0;
    drive_word(32'h0100_0000, 32'h300, 1'b0);
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 32'h0100_0000, 32'h302};
    if (obs !== exp_v) begin
      $display("FAIL misaligned got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    idle_pf();
    step();
    if (o_valid !== 1'b0) begin
      $display("FAIL misaligned_once got=%b exp=0", o_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_illegal();
    drive_word(32'h8001_8002, 32'h400, 1'b1);
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 32'h8001_8002, 32'h400};
    if (obs !== exp_v) begin
      $display("FAIL illegal_word got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    idle_pf();
    step();
    if (o_valid !== 1'b0) begin
      $display("FAIL illegal_once got=%b exp=0", o_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_stall_flush();
    stalled_n = 1'b0;
    drive_word(32'h8001_8002, 32'h500, 1'b0);
    step();
    idle_pf();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 32'h8001_0000, 32'h500};
    if (obs !== exp_v) begin
      $display("FAIL stall_first got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== exp_v) begin
        $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp_v); failures++;
      end
      checks++;
    end
    new_pc = 1'b1; pc = 32'h600;
    step();
    new_pc = 1'b0;
    if (o_valid !== 1'b0) begin
      $display("FAIL stall_flush got=%b exp=0", o_valid); failures++;
    end
    checks++;
    stalled_n = 1'b1;
    step();
    if (o_valid !== 1'b0) begin
      $display("FAIL stall_no_lo got=%b exp=0", o_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    drive_word(32'h8005_8006, 32'h900, 1'b0);
    step();
    drive_word(32'h0300_0000, 32'h904, 1'b0);
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 32'h8005_0000, 32'h900};
    if (obs !== exp_v) begin
      $display("FAIL b2b_hi got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 32'h8006_0000, 32'h902};
    if (obs !== exp_v) begin
      $display("FAIL b2b_lo got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
    idle_pf();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 32'h0300_0000, 32'h904};
    if (obs !== exp_v) begin
      $display("FAIL b2b_full got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
  endtask

  task automatic test_clear_cache();
    clear_cache = 1'b1; pc = 32'h302;
    drive_word(32'h0400_0000, 32'hA00, 1'b0);
    step();
    clear_cache = 1'b0;
    if (o_valid !== 1'b0) begin
      $display("FAIL clear_drops_accept got=%b exp=0", o_valid); failures++;
    end
    checks++;
    drive_word(32'h0500_0000, 32'hA04, 1'b0);
    step();
    idle_pf();
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 32'h0500_0000, 32'hA04};
    if (obs !== exp_v) begin
      $display("FAIL clear_next got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
  endtask

  task automatic test_async_reset();
    drive_word(32'h8001_8002, 32'h700, 1'b0);
    step();
    idle_pf();
    step();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 32'h8002_0000, 32'h702};
    if (obs !== exp_v) begin
      $display("FAIL pre_reset_lo got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    if (obs !== exp_v) begin
      $display("FAIL async_reset got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    drive_word(32'h8003_8004, 32'h800, 1'b0);
    step();
    idle_pf();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 32'h8003_0000, 32'h800};
    if (obs !== exp_v) begin
      $display("FAIL post_reset_hi got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
    exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 32'h8004_0000, 32'h802};
    if (obs !== exp_v) begin
      $display("FAIL post_reset_lo got=%h exp=%h", obs, exp_v); failures++;
    end
    checks++;
    step();
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_cis_split();
    test_low_target();
    test_illegal();
    test_stall_flush();
    test_back_to_back();
    test_clear_cache();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
